jtag_ocimem_ctrl: RTL and testbench

JTAG_OCIMEM_CTRL -- requirements
Module: jtag_ocimem_ctrl

---
 rtl/jtag_ocimem_ctrl_if.sv | 27 ++
 rtl/jtag_ocimem_ctrl.sv | 100 ++++++++++
 tb/tb_jtag_ocimem_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_ocimem_ctrl_if.sv
// jtag_ocimem_ctrl_if: JTAG strobe/monitor signals and CPU slave port of the debug RAM.
interface jtag_ocimem_ctrl_if;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        monitor_ready;
    logic        monitor_error;
    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest, MonDReg, MonAReg, monitor_ready, monitor_error
    );
    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest, MonDReg, MonAReg, monitor_ready, monitor_error
    );
endinterface

// File: rtl/jtag_ocimem_ctrl.sv
// jtag_ocimem_ctrl: debug RAM shared between JTAG monitor strobes and a CPU slave port.
// JTAG always wins; a strobe arriving while busy waits in a one-deep pending slot.
module jtag_ocimem_ctrl #(
    parameter int MEM_WORDS = 64
) (
    input  logic clk,
    input  logic reset,
    jtag_ocimem_ctrl_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    typedef enum logic [1:0] {IDLE, J_RD, J_CAP, C_RD} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_A, OP_B, OP_N} op_t;
    state_t      state;
    op_t         live_op, op, pend_op;
    logic        pend_valid, rd_inc, idle, cpu_ok, cpu_wr, cpu_rd, in_rng, ram_we;
    logic [31:0] pend_d, op_d;
    logic [7:0]  ram_addr;
    logic [AW-1:0] idx;
    logic [31:0] mem [MEM_WORDS];
    logic        unused_jdo;
    assign unused_jdo = ^{bus.jdo[37:35], bus.jdo[2:0]};
    // op_d holds jdo[34:3]: data [31:0], address [30:23], read request [31]
    always_comb begin
        live_op = bus.take_action_ocimem_a    ? OP_A :
                  bus.take_action_ocimem_b    ? OP_B :
                  bus.take_no_action_ocimem_a ? OP_N : OP_NONE;
        idle     = state == IDLE;
        op       = pend_valid ? pend_op : live_op;
        op_d     = pend_valid ? pend_d : bus.jdo[34:3];
        cpu_ok   = idle && op == OP_NONE;
        cpu_wr   = cpu_ok && bus.avs_write;
        cpu_rd   = cpu_ok && bus.avs_read && !bus.avs_write;
        ram_addr = cpu_ok ? bus.avs_address : bus.MonAReg;
        in_rng   = 32'(ram_addr) < MEM_WORDS;
        idx      = ram_addr[AW-1:0];
        ram_we   = !reset && in_rng && (cpu_wr || (idle && op == OP_B));
        bus.avs_waitrequest = !reset && (bus.avs_write ? !cpu_wr : bus.avs_read && state != C_RD);
    end
    always_ff @(posedge clk)
        if (ram_we) mem[idx] <= cpu_wr ? bus.avs_writedata : op_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            pend_valid        <= 1'b0;
            pend_op           <= OP_NONE;
            pend_d            <= '0;
            rd_inc            <= 1'b0;
            bus.MonAReg       <= '0;
            bus.MonDReg       <= '0;
            bus.monitor_ready <= 1'b0;
            bus.monitor_error <= 1'b0;
            bus.avs_readdata  <= '0;
        end else begin
            case (state)
                IDLE: case (op)
                    OP_A: begin
                        bus.MonAReg       <= op_d[30:23];
                        bus.monitor_ready <= 1'b0;
                        bus.monitor_error <= 1'b0;
                        rd_inc            <= 1'b0;
                        if (op_d[31]) state <= J_RD;
                    end
                    OP_B: begin
                        bus.MonAReg       <= bus.MonAReg + 8'd1;
                        bus.monitor_ready <= 1'b1;
                        bus.monitor_error <= !in_rng;
                    end
                    OP_N: begin
                        bus.monitor_ready <= 1'b0;
                        bus.monitor_error <= 1'b0;
                        rd_inc            <= 1'b1;
                        state             <= J_RD;
                    end
                    default: if (cpu_rd) begin
                        bus.avs_readdata <= in_rng ? mem[idx] : '0;
                        state            <= C_RD;
                    end
                endcase
                J_RD: begin
                    if (in_rng) bus.MonDReg <= mem[idx];
                    if (rd_inc) bus.MonAReg <= bus.MonAReg + 8'd1;
                    bus.monitor_ready <= 1'b1;
                    bus.monitor_error <= !in_rng;
                    state             <= J_CAP;
                end
                default: state <= IDLE;
            endcase
            // Serving the slot frees it, so a strobe in that same cycle may refill it
            if (idle && pend_valid) begin
                pend_valid <= live_op != OP_NONE;
                pend_op    <= live_op;
                pend_d     <= bus.jdo[34:3];
            end else if (!idle && !pend_valid && live_op != OP_NONE) begin
                pend_valid <= 1'b1;
                pend_op    <= live_op;
                pend_d     <= bus.jdo[34:3];
            end
        end
    end
endmodule

// File: tb/tb_jtag_ocimem_ctrl.sv
// tb_jtag_ocimem_ctrl: directed checks of JTAG/CPU access, arbitration, pending and reset.
module tb_jtag_ocimem_ctrl;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    jtag_ocimem_ctrl_if bus();
    jtag_ocimem_ctrl #(.MEM_WORDS(64)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd);
        return {3'b000, rd, a, 26'b0};
    endfunction
    function automatic logic [37:0] mk_b(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_inputs();
        bus.jdo = '0;
        bus.take_action_ocimem_a = 0;
        bus.take_action_ocimem_b = 0;
        bus.take_no_action_ocimem_a = 0;
        bus.avs_address = '0;
        bus.avs_read = 0;
        bus.avs_write = 0;
        bus.avs_writedata = '0;
    endtask
    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        checks++; if (bus.MonAReg !== 8'h00) begin failures++; $display("FAIL rst_areg got=%h exp=00", bus.MonAReg); end
        checks++; if (bus.MonDReg !== 32'h0) begin failures++; $display("FAIL rst_dreg got=%h exp=0", bus.MonDReg); end
        checks++; if (bus.monitor_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.monitor_ready); end
        checks++; if (bus.monitor_error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", bus.monitor_error); end
        checks++; if (bus.avs_readdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.avs_readdata); end
        checks++; if (bus.avs_waitrequest !== 1'b0) begin failures++; $display("FAIL rst_wait got=%b exp=0", bus.avs_waitrequest); end
        reset = 0;
        step();
    endtask
    task automatic test_jtag_write();
        bus.jdo = mk_a(8'h05, 1'b0); bus.take_action_ocimem_a = 1;
        step();
        bus.take_action_ocimem_a = 0;
        checks++; if (bus.MonAReg !== 8'h05) begin failures++; $display("FAIL wr_load got=%h exp=05", bus.MonAReg); end
        bus.jdo = mk_b(32'hDEADBEEF); bus.take_action_ocimem_b = 1;
        step();
        bus.take_action_ocimem_b = 0;
        checks++; if (bus.monitor_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", bus.monitor_ready); end
        checks++; if (bus.monitor_error !== 1'b0) begin failures++; $display("FAIL wr_error got=%b exp=0", bus.monitor_error); end
        checks++; if (bus.MonAReg !== 8'h06) begin failures++; $display("FAIL wr_inc got=%h exp=06", bus.MonAReg); end
    endtask
    task automatic test_jtag_read();
        bus.jdo = mk_a(8'h05, 1'b1); bus.take_action_ocimem_a = 1;
        step();
        bus.take_action_ocimem_a = 0;
        checks++; if (bus.monitor_ready !== 1'b0) begin failures++; $display("FAIL rd_ready_n1 got=%b exp=0", bus.monitor_ready); end
        step();
        checks++; if (bus.monitor_ready !== 1'b1) begin failures++; $display("FAIL rd_ready_n2 got=%b exp=1", bus.monitor_ready); end
        checks++; if (bus.MonDReg !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", bus.MonDReg); end
        checks++; if (bus.MonAReg !== 8'h05) begin failures++; $display("FAIL rd_addr got=%h exp=05", bus.MonAReg); end
        step();
        bus.take_no_action_ocimem_a = 1;
        step();
        bus.take_no_action_ocimem_a = 0;
        step();
        checks++; if (bus.MonAReg !== 8'h06) begin failures++; $display("FAIL na_inc got=%h exp=06", bus.MonAReg); end
        checks++; if (bus.MonDReg !== 32'hDEADBEEF) begin failures++; $display("FAIL na_data got=%h exp=deadbeef", bus.MonDReg); end
        step();
    endtask
    task automatic test_error();
        bus.jdo = mk_a(8'hFF, 1'b0); bus.take_action_ocimem_a = 1;
        step();
        bus.take_action_ocimem_a = 0;
        bus.take_no_action_ocimem_a = 1;
        step();
        bus.take_no_action_ocimem_a = 0;
        step();
        checks++; if (bus.monitor_error !== 1'b1) begin failures++; $display("FAIL oob_rd_error got=%b exp=1", bus.monitor_error); end
        checks++; if (bus.monitor_ready !== 1'b1) begin failures++; $display("FAIL oob_rd_ready got=%b exp=1", bus.monitor_ready); end
        checks++; if (bus.MonDReg !== 32'hDEADBEEF) begin failures++; $display("FAIL oob_rd_data got=%h exp=deadbeef", bus.MonDReg); end
        checks++; if (bus.MonAReg !== 8'h00) begin failures++; $display("FAIL oob_wrap got=%h exp=00", bus.MonAReg); end
        step();
        bus.jdo = mk_a(8'h40, 1'b0); bus.take_action_ocimem_a = 1;
        step();
        bus.take_action_ocimem_a = 0;
        checks++; if (bus.monitor_error !== 1'b0) begin failures++; $display("FAIL load_clr_error got=%b exp=0", bus.monitor_error); end
        bus.jdo = mk_b(32'h0BADF00D); bus.take_action_ocimem_b = 1;
        step();
        bus.take_action_ocimem_b = 0;
        checks++; if (bus.monitor_error !== 1'b1) begin failures++; $display("FAIL oob_wr_error got=%b exp=1", bus.monitor_error); end
        checks++; if (bus.MonAReg !== 8'h41) begin failures++; $display("FAIL oob_wr_inc got=%h exp=41", bus.MonAReg); end
    endtask
    task automatic test_cpu();
        bus.avs_address = 8'h07; bus.avs_writedata = 32'hCAFEF00D; bus.avs_write = 1;
        #1;
        checks++; if (bus.avs_waitrequest !== 1'b0) begin failures++; $display("FAIL cpu_wr_wait got=%b exp=0", bus.avs_waitrequest); end
        step();
        bus.avs_write = 0; bus.avs_read = 1;
        #1;
        checks++; if (bus.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL cpu_rd_wait1 got=%b exp=1", bus.avs_waitrequest); end
        step();
        checks++; if (bus.avs_waitrequest !== 1'b0) begin failures++; $display("FAIL cpu_rd_wait0 got=%b exp=0", bus.avs_waitrequest); end
        checks++; if (bus.avs_readdata !== 32'hCAFEF00D) begin failures++; $display("FAIL cpu_rd_data got=%h exp=cafef00d", bus.avs_readdata); end
        bus.avs_read = 0;
        step();
        bus.avs_address = 8'h40; bus.avs_read = 1;
        step(); step();
        checks++; if (bus.avs_readdata !== 32'h0) begin failures++; $display("FAIL cpu_oob_rd got=%h exp=0", bus.avs_readdata); end
        bus.avs_read = 0;
        step();
        bus.jdo = mk_a(8'h07, 1'b1); bus.take_action_ocimem_a = 1;
        step();
        bus.take_action_ocimem_a = 0;
        step();
        checks++; if (bus.MonDReg !== 32'hCAFEF00D) begin failures++; $display("FAIL cpu_to_jtag got=%h exp=cafef00d", bus.MonDReg); end
        step();
    endtask
    task automatic test_contention();
        bus.avs_address = 8'h05; bus.avs_read = 1;
        bus.jdo = mk_a(8'h05, 1'b1); bus.take_action_ocimem_a = 1;
        #1;
        checks++; if (bus.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL ct_wait_n got=%b exp=1", bus.avs_waitrequest); end
        step();
        bus.take_action_ocimem_a = 0;
        checks++; if (bus.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL ct_wait_jrd got=%b exp=1", bus.avs_waitrequest); end
        step();
        checks++; if (bus.MonDReg !== 32'hDEADBEEF) begin failures++; $display("FAIL ct_jtag_data got=%h exp=deadbeef", bus.MonDReg); end
        checks++; if (bus.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL ct_wait_jcap got=%b exp=1", bus.avs_waitrequest); end
        step();
        checks++; if (bus.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL ct_wait_acc got=%b exp=1", bus.avs_waitrequest); end
        step();
        checks++; if (bus.avs_waitrequest !== 1'b0) begin failures++; $display("FAIL ct_wait_crd got=%b exp=0", bus.avs_waitrequest); end
        checks++; if (bus.avs_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ct_cpu_data got=%h exp=deadbeef", bus.avs_readdata); end
        bus.avs_read = 0;
        step();
        bus.avs_address = 8'h08; bus.avs_writedata = 32'h11112222; bus.avs_write = 1;
        bus.jdo = mk_a(8'h05, 1'b0); bus.take_action_ocimem_a = 1;
        #1;
        checks++; if (bus.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL ct_wr_wait got=%b exp=1", bus.avs_waitrequest); end
        step();
        bus.take_action_ocimem_a = 0; bus.avs_write = 0;
    endtask
    task automatic test_pending();
        bus.avs_address = 8'h07; bus.avs_read = 1;
        step();
        bus.jdo = mk_a(8'h09, 1'b0); bus.take_action_ocimem_a = 1; bus.take_action_ocimem_b = 1;
        #1;
        checks++; if (bus.avs_readdata !== 32'hCAFEF00D) begin failures++; $display("FAIL pd_cpu_data got=%h exp=cafef00d", bus.avs_readdata); end
        step();
        bus.take_action_ocimem_a = 0; bus.take_action_ocimem_b = 0; bus.avs_read = 0;
        checks++; if (bus.MonAReg !== 8'h05) begin failures++; $display("FAIL pd_not_yet got=%h exp=05", bus.MonAReg); end
        step();
        checks++; if (bus.MonAReg !== 8'h09) begin failures++; $display("FAIL pd_served got=%h exp=09", bus.MonAReg); end
        step();
        checks++; if (bus.MonAReg !== 8'h09) begin failures++; $display("FAIL pd_b_dropped got=%h exp=09", bus.MonAReg); end
        checks++; if (bus.monitor_ready !== 1'b0) begin failures++; $display("FAIL pd_ready got=%b exp=0", bus.monitor_ready); end
    endtask
    task automatic test_read_write_both();
        bus.avs_address = 8'h08; bus.avs_writedata = 32'h33334444; bus.avs_write = 1; bus.avs_read = 1;
        #1;
        checks++; if (bus.avs_waitrequest !== 1'b0) begin failures++; $display("FAIL rw_wait got=%b exp=0", bus.avs_waitrequest); end
        step();
        bus.avs_write = 0;
        step(); step();
        checks++; if (bus.avs_readdata !== 32'h33334444) begin failures++; $display("FAIL rw_data got=%h exp=33334444", bus.avs_readdata); end
        bus.avs_read = 0;
        step();
    endtask
    task automatic test_reset_mid();
        bus.jdo = mk_a(8'h05, 1'b1); bus.take_action_ocimem_a = 1;
        step();
        bus.take_action_ocimem_a = 0;
        reset = 1;
        step();
        reset = 0;
        checks++; if (bus.MonAReg !== 8'h00) begin failures++; $display("FAIL rm_areg got=%h exp=00", bus.MonAReg); end
        checks++; if (bus.MonDReg !== 32'h0) begin failures++; $display("FAIL rm_dreg got=%h exp=0", bus.MonDReg); end
        checks++; if (bus.monitor_ready !== 1'b0) begin failures++; $display("FAIL rm_ready got=%b exp=0", bus.monitor_ready); end
        checks++; if (bus.avs_readdata !== 32'h0) begin failures++; $display("FAIL rm_rdata got=%h exp=0", bus.avs_readdata); end
        step();
        checks++; if (bus.monitor_ready !== 1'b0) begin failures++; $display("FAIL rm_ready_hold got=%b exp=0", bus.monitor_ready); end
        checks++; if (bus.MonDReg !== 32'h0) begin failures++; $display("FAIL rm_dreg_hold got=%h exp=0", bus.MonDReg); end
    endtask
    initial begin
        test_reset();
        test_jtag_write();
        test_jtag_read();
        test_error();
        test_cpu();
        test_contention();
        test_pending();
        test_read_write_both();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
